// File: rtl/piso_stream.sv
// Flow-controlled parallel-in/serial-out serialiser: variable-length words in,
// one bit per cycle out (MSB- or LSB-first per word) with an end-of-word marker.
module piso_stream #(
    parameter  int WIDTH = 8,
    localparam int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LW-1:0]    in_len,
    input  logic             in_msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    logic             r_hold_vld;
    logic [WIDTH-1:0] r_hold_data;
    logic [LW-1:0]    r_hold_len;
    logic             r_hold_msb;

    logic             r_sh_vld;
    logic [WIDTH-1:0] r_sh_reg;
    logic [LW-1:0]    r_cnt;
    logic             r_sh_msb;

    logic [LW-1:0]    w_len;
    logic             w_in_xfer;
    logic             w_in_keep;
    logic             w_out_fire;
    logic             w_last;
    logic             w_sh_free;
    logic             w_load_hold;
    logic             w_load_in;

    // MSB-first words are left-aligned so the next bit always sits at WIDTH-1.
    function automatic logic [WIDTH-1:0] align_word(
        input logic [WIDTH-1:0] d,
        input logic [LW-1:0]    len,
        input logic             msb
    );
        return msb ? (d << (LW'(WIDTH) - len)) : d;
    endfunction

    assign w_len       = (in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
    assign in_ready    = !r_hold_vld && !flush;
    assign w_in_xfer   = in_valid && in_ready;
    assign w_in_keep   = w_in_xfer && (w_len != '0);
    assign w_out_fire  = r_sh_vld && out_ready;
    assign w_last      = r_sh_vld && (r_cnt == LW'(1));
    assign w_sh_free   = !r_sh_vld || (w_out_fire && w_last);
    assign w_load_hold = w_sh_free && r_hold_vld;
    assign w_load_in   = w_sh_free && !r_hold_vld && w_in_keep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            r_hold_len  <= '0;
            r_hold_msb  <= 1'b0;
            r_sh_vld    <= 1'b0;
            r_sh_reg    <= '0;
            r_cnt       <= '0;
            r_sh_msb    <= 1'b0;
        end else if (flush) begin
            r_hold_vld <= 1'b0;
            r_sh_vld   <= 1'b0;
            r_sh_reg   <= '0;
            r_cnt      <= '0;
        end else begin
            // Holding register: drains into the shift stage, or catches a word
            // that could not bypass straight into it.
            if (w_load_hold) begin
                r_hold_vld <= 1'b0;
            end else if (w_in_keep && !w_load_in) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= in_data;
                r_hold_len  <= w_len;
                r_hold_msb  <= in_msb_first;
            end

            if (w_load_hold) begin
                r_sh_vld <= 1'b1;
                r_sh_reg <= align_word(r_hold_data, r_hold_len, r_hold_msb);
                r_cnt    <= r_hold_len;
                r_sh_msb <= r_hold_msb;
            end else if (w_load_in) begin
                r_sh_vld <= 1'b1;
                r_sh_reg <= align_word(in_data, w_len, in_msb_first);
                r_cnt    <= w_len;
                r_sh_msb <= in_msb_first;
            end else if (w_sh_free) begin
                r_sh_vld <= 1'b0;
                r_sh_reg <= '0;
                r_cnt    <= '0;
            end else if (w_out_fire) begin
                r_sh_reg <= r_sh_msb ? (r_sh_reg << 1) : (r_sh_reg >> 1);
                r_cnt    <= r_cnt - LW'(1);
            end
        end
    end

    assign out_valid = r_sh_vld;
    assign out_bit   = r_sh_msb ? r_sh_reg[WIDTH-1] : r_sh_reg[0];
    assign out_last  = w_last;
    assign busy      = r_hold_vld || r_sh_vld;

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream: directed scenarios plus randomized words
// compared against a bit-queue reference model.
module tb_piso_stream;

    localparam int W  = 8;
    localparam int LW = 4;

    typedef struct {
        logic [W-1:0]  data;
        logic [LW-1:0] len;
        logic          msb;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [LW-1:0] in_len = '0;
    logic          in_msb_first = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, out_bit, out_last, busy;

    int n_pass = 0;
    int n_total = 0;

    word_t wq[$];
    logic  exp_bit[$], exp_last[$], obs_bit[$], obs_last[$];
    logic  tr_valid[$], tr_bit[$], tr_last[$], tr_ordy[$], tr_inrdy[$], tr_busy[$], tr_acc[$];
    bit    run_ok;

    piso_stream #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_len       (in_len),
        .in_msb_first (in_msb_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bit      (out_bit),
        .out_last     (out_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic clear_all();
        wq.delete(); exp_bit.delete(); exp_last.delete(); obs_bit.delete(); obs_last.delete();
        tr_valid.delete(); tr_bit.delete(); tr_last.delete(); tr_ordy.delete();
        tr_inrdy.delete(); tr_busy.delete(); tr_acc.delete();
    endtask

    // Reference: a word contributes min(len,W) bits, taken from the top of the
    // used field downward (MSB) or from bit 0 upward (LSB); last flag on the final one.
    task automatic model_word(input word_t w);
        int l;
        l = (int'(w.len) > W) ? W : int'(w.len);
        for (int i = 0; i < l; i++) begin
            exp_bit.push_back(w.msb ? w.data[l-1-i] : w.data[i]);
            exp_last.push_back(i == l - 1);
        end
    endtask

    task automatic model_all();
        foreach (wq[k]) model_word(wq[k]);
    endtask

    // One cycle: called just after a falling edge with inputs already driven.
    task automatic step_rec();
        #1;
        tr_valid.push_back(out_valid);
        tr_bit.push_back(out_bit);
        tr_last.push_back(out_last);
        tr_ordy.push_back(out_ready);
        tr_inrdy.push_back(in_ready);
        tr_busy.push_back(busy);
        tr_acc.push_back(in_valid && in_ready);
        if (out_valid && out_ready) begin
            obs_bit.push_back(out_bit);
            obs_last.push_back(out_last);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_words(input int ordy_mode, input bit vgap, input int budget);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while ((idx < wq.size() || busy) && cyc < budget) begin
            in_valid = (idx < wq.size()) && (!vgap || $urandom_range(0, 2) != 0);
            if (idx < wq.size()) begin
                in_data      = wq[idx].data;
                in_len       = wq[idx].len;
                in_msb_first = wq[idx].msb;
            end
            if (ordy_mode == 0)      out_ready = 1'b1;
            else if (ordy_mode == 1) out_ready = (cyc % 2 == 0);
            else                     out_ready = 1'($urandom_range(0, 1));
            step_rec();
            if (tr_acc[$] === 1'b1) begin
                $display("word %0d accepted: data=%h len=%0d msb=%b cycle=%0d",
                         idx, wq[idx].data, wq[idx].len, wq[idx].msb, cyc);
                idx++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        run_ok = (idx == wq.size()) && !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", out_valid); else n_pass++;
        n_total++; if (out_bit !== 1'b0)   $display("FAIL reset_out_bit: got %b, expected 0", out_bit); else n_pass++;
        n_total++; if (out_last !== 1'b0)  $display("FAIL reset_out_last: got %b, expected 0", out_last); else n_pass++;
        n_total++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
        n_total++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b, expected 1", in_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_msb_a5();
        int a;
        clear_all();
        wq.push_back('{8'hA5, 4'd8, 1'b1});
        model_all();
        run_words(0, 0, 100);
        n_total++; if (!run_ok) $display("FAIL a5_done: got timeout, expected word drained"); else n_pass++;
        n_total++;
        if (obs_bit.size() != exp_bit.size()) $display("FAIL a5_count: got %0d bits, expected %0d", obs_bit.size(), exp_bit.size());
        else n_pass++;
        foreach (exp_bit[i]) begin
            n_total++;
            if (i < obs_bit.size() && obs_bit[i] === exp_bit[i] && obs_last[i] === exp_last[i]) n_pass++;
            else $display("FAIL a5_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", i,
                          (i < obs_bit.size()) ? obs_bit[i] : 1'bx, (i < obs_last.size()) ? obs_last[i] : 1'bx,
                          exp_bit[i], exp_last[i]);
        end
        a = 0;
        while (a < tr_acc.size() && tr_acc[a] !== 1'b1) a++;
        n_total++;
        if (a + 1 >= tr_valid.size() || tr_valid[a] !== 1'b0 || tr_valid[a+1] !== 1'b1)
            $display("FAIL a5_latency: got valid before/after accept %b/%b, expected 0/1",
                     (a < tr_valid.size()) ? tr_valid[a] : 1'bx, (a + 1 < tr_valid.size()) ? tr_valid[a+1] : 1'bx);
        else n_pass++;
        #1;
        n_total++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL a5_idle: got busy=%b valid=%b, expected 0/0", busy, out_valid); else n_pass++;
    endtask

    task automatic test_lsb_msb_06();
        clear_all();
        wq.push_back('{8'h06, 4'd3, 1'b0});
        wq.push_back('{8'h06, 4'd3, 1'b1});
        model_all();
        run_words(0, 0, 100);
        n_total++; if (!run_ok) $display("FAIL w06_done: got timeout, expected words drained"); else n_pass++;
        n_total++;
        if (obs_bit.size() != exp_bit.size()) $display("FAIL w06_count: got %0d bits, expected %0d", obs_bit.size(), exp_bit.size());
        else n_pass++;
        foreach (exp_bit[i]) begin
            n_total++;
            if (i < obs_bit.size() && obs_bit[i] === exp_bit[i] && obs_last[i] === exp_last[i]) n_pass++;
            else $display("FAIL w06_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", i,
                          (i < obs_bit.size()) ? obs_bit[i] : 1'bx, (i < obs_last.size()) ? obs_last[i] : 1'bx,
                          exp_bit[i], exp_last[i]);
        end
    endtask

    task automatic test_back_to_back();
        int a1, j, f, nv, nwin;
        bit bad;
        clear_all();
        wq.push_back('{8'hFF, 4'd8, 1'b1});
        wq.push_back('{8'h00, 4'd4, 1'b1});
        model_all();
        run_words(0, 0, 100);
        n_total++; if (!run_ok) $display("FAIL b2b_done: got timeout, expected words drained"); else n_pass++;
        n_total++;
        if (obs_bit.size() != exp_bit.size()) $display("FAIL b2b_count: got %0d bits, expected %0d", obs_bit.size(), exp_bit.size());
        else n_pass++;
        foreach (exp_bit[i]) begin
            n_total++;
            if (i < obs_bit.size() && obs_bit[i] === exp_bit[i] && obs_last[i] === exp_last[i]) n_pass++;
            else $display("FAIL b2b_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", i,
                          (i < obs_bit.size()) ? obs_bit[i] : 1'bx, (i < obs_last.size()) ? obs_last[i] : 1'bx,
                          exp_bit[i], exp_last[i]);
        end
        // The 12 valid cycles must form one unbroken run.
        f = 0;
        while (f < tr_valid.size() && tr_valid[f] !== 1'b1) f++;
        nv = 0; nwin = 0;
        foreach (tr_valid[i]) begin
            if (tr_valid[i] === 1'b1) nv++;
            if (i >= f && i < f + 12 && tr_valid[i] === 1'b1) nwin++;
        end
        n_total++;
        if (nv != 12 || nwin != 12) $display("FAIL b2b_contiguous: got %0d valid (%0d in window), expected 12/12", nv, nwin);
        else n_pass++;
        // in_ready low from the cycle after the second word is held until the first word's last bit.
        a1 = -1; j = -1;
        foreach (tr_acc[i]) if (tr_acc[i] === 1'b1) a1 = i;
        foreach (tr_valid[i]) if (j < 0 && tr_valid[i] === 1'b1 && tr_ordy[i] === 1'b1 && tr_last[i] === 1'b1) j = i;
        bad = (a1 < 0) || (j <= a1);
        for (int k = a1 + 1; k <= j && k < tr_inrdy.size(); k++) if (tr_inrdy[k] !== 1'b0) bad = 1'b1;
        n_total++; if (bad) $display("FAIL b2b_in_ready_low: got in_ready high while held (accept=%0d last=%0d), expected low", a1, j); else n_pass++;
        n_total++;
        if (j < 0 || j + 1 >= tr_inrdy.size() || tr_inrdy[j+1] !== 1'b1)
            $display("FAIL b2b_in_ready_rise: got %b after first last bit, expected 1",
                     (j >= 0 && j + 1 < tr_inrdy.size()) ? tr_inrdy[j+1] : 1'bx);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        clear_all();
        wq.push_back('{8'hC3, 4'd8, 1'b1});
        model_all();
        run_words(1, 0, 100);
        n_total++; if (!run_ok) $display("FAIL bp_done: got timeout, expected word drained"); else n_pass++;
        n_total++;
        if (obs_bit.size() != exp_bit.size()) $display("FAIL bp_count: got %0d bits, expected %0d", obs_bit.size(), exp_bit.size());
        else n_pass++;
        foreach (exp_bit[i]) begin
            n_total++;
            if (i < obs_bit.size() && obs_bit[i] === exp_bit[i] && obs_last[i] === exp_last[i]) n_pass++;
            else $display("FAIL bp_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", i,
                          (i < obs_bit.size()) ? obs_bit[i] : 1'bx, (i < obs_last.size()) ? obs_last[i] : 1'bx,
                          exp_bit[i], exp_last[i]);
        end
        for (int i = 0; i + 1 < tr_valid.size(); i++) begin
            if (tr_valid[i] === 1'b1 && tr_ordy[i] === 1'b0) begin
                n_total++;
                if (tr_valid[i+1] !== 1'b1 || tr_bit[i+1] !== tr_bit[i] || tr_last[i+1] !== tr_last[i])
                    $display("FAIL bp_stable%0d: got valid=%b bit=%b last=%b, expected valid=1 bit=%b last=%b",
                             i, tr_valid[i+1], tr_bit[i+1], tr_last[i+1], tr_bit[i], tr_last[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_len_zero();
        int nacc, nv;
        clear_all();
        wq.push_back('{8'h55, 4'd0, 1'b1});
        run_words(0, 0, 20);
        repeat (4) step_rec();
        nacc = 0; nv = 0;
        foreach (tr_acc[i]) if (tr_acc[i] === 1'b1) nacc++;
        foreach (tr_valid[i]) if (tr_valid[i] !== 1'b0 || tr_busy[i] !== 1'b0) nv++;
        n_total++; if (nacc != 1) $display("FAIL len0_accept: got %0d accepts, expected 1", nacc); else n_pass++;
        n_total++; if (nv != 0) $display("FAIL len0_silent: got %0d cycles valid/busy, expected 0", nv); else n_pass++;
        // A zero-length word between two real words must not occupy a slot.
        clear_all();
        wq.push_back('{8'hFF, 4'd4, 1'b1});
        wq.push_back('{8'h00, 4'd0, 1'b0});
        wq.push_back('{8'h03, 4'd2, 1'b0});
        model_all();
        run_words(0, 0, 100);
        n_total++; if (!run_ok) $display("FAIL len0_mix_done: got timeout, expected words drained"); else n_pass++;
        n_total++;
        if (obs_bit.size() != exp_bit.size()) $display("FAIL len0_mix_count: got %0d bits, expected %0d", obs_bit.size(), exp_bit.size());
        else n_pass++;
        foreach (exp_bit[i]) begin
            n_total++;
            if (i < obs_bit.size() && obs_bit[i] === exp_bit[i] && obs_last[i] === exp_last[i]) n_pass++;
            else $display("FAIL len0_mix_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", i,
                          (i < obs_bit.size()) ? obs_bit[i] : 1'bx, (i < obs_last.size()) ? obs_last[i] : 1'bx,
                          exp_bit[i], exp_last[i]);
        end
    endtask

    task automatic test_len_clamp();
        clear_all();
        wq.push_back('{8'h5A, 4'd12, 1'b1});
        wq.push_back('{8'h5A, 4'd15, 1'b0});
        model_all();
        run_words(0, 0, 100);
        n_total++; if (!run_ok) $display("FAIL clamp_done: got timeout, expected words drained"); else n_pass++;
        n_total++;
        if (obs_bit.size() != exp_bit.size()) $display("FAIL clamp_count: got %0d bits, expected %0d", obs_bit.size(), exp_bit.size());
        else n_pass++;
        foreach (exp_bit[i]) begin
            n_total++;
            if (i < obs_bit.size() && obs_bit[i] === exp_bit[i] && obs_last[i] === exp_last[i]) n_pass++;
            else $display("FAIL clamp_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", i,
                          (i < obs_bit.size()) ? obs_bit[i] : 1'bx, (i < obs_last.size()) ? obs_last[i] : 1'bx,
                          exp_bit[i], exp_last[i]);
        end
    endtask

    task automatic test_flush();
        int nv;
        clear_all();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hB4; in_len = 4'd8; in_msb_first = 1'b1;
        step_rec();
        in_data = 8'h3C; in_len = 4'd5; in_msb_first = 1'b0;
        step_rec();
        in_valid = 1'b0;
        step_rec();
        step_rec();
        n_total++;
        if (obs_bit.size() != 3 || obs_bit[0] !== 1'b1 || obs_bit[1] !== 1'b0 || obs_bit[2] !== 1'b1)
            $display("FAIL flush_prefix: got %0d bits, expected 3 bits 1,0,1", obs_bit.size());
        else n_pass++;
        #1;
        n_total++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL flush_held: got in_ready=%b busy=%b, expected 0/1", in_ready, busy); else n_pass++;
        flush = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF; in_len = 4'd8; in_msb_first = 1'b1;
        step_rec();
        n_total++; if (tr_inrdy[$] !== 1'b0) $display("FAIL flush_in_ready: got %b during flush, expected 0", tr_inrdy[$]); else n_pass++;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b, expected 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0)      $display("FAIL flush_busy: got %b, expected 0", busy); else n_pass++;
        n_total++; if (in_ready !== 1'b1)  $display("FAIL flush_in_ready_after: got %b, expected 1", in_ready); else n_pass++;
        @(negedge clk);
        tr_valid.delete();
        repeat (10) step_rec();
        nv = 0;
        foreach (tr_valid[i]) if (tr_valid[i] !== 1'b0) nv++;
        n_total++; if (nv != 0) $display("FAIL flush_gone: got %0d valid cycles after flush, expected 0", nv); else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_all();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hF0; in_len = 4'd8; in_msb_first = 1'b1;
        step_rec();
        in_valid = 1'b0;
        step_rec();
        step_rec();
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rstmid_outputs: got valid=%b bit=%b last=%b busy=%b in_ready=%b, expected 0/0/0/0/1",
                     out_valid, out_bit, out_last, busy, in_ready);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_all();
        wq.push_back('{8'h05, 4'd3, 1'b1});
        model_all();
        run_words(0, 0, 100);
        n_total++; if (tr_valid.size() == 0 || tr_valid[0] !== 1'b0) $display("FAIL rstmid_no_remnant: got valid before new word, expected 0"); else n_pass++;
        n_total++;
        if (obs_bit.size() != exp_bit.size()) $display("FAIL rstmid_count: got %0d bits, expected %0d", obs_bit.size(), exp_bit.size());
        else n_pass++;
        foreach (exp_bit[i]) begin
            n_total++;
            if (i < obs_bit.size() && obs_bit[i] === exp_bit[i] && obs_last[i] === exp_last[i]) n_pass++;
            else $display("FAIL rstmid_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", i,
                          (i < obs_bit.size()) ? obs_bit[i] : 1'bx, (i < obs_last.size()) ? obs_last[i] : 1'bx,
                          exp_bit[i], exp_last[i]);
        end
    endtask

    task automatic test_random();
        clear_all();
        for (int k = 0; k < 40; k++)
            wq.push_back('{W'($urandom), LW'($urandom_range(0, 15)), 1'($urandom_range(0, 1))});
        model_all();
        run_words(2, 1, 4000);
        n_total++; if (!run_ok) $display("FAIL rand_done: got timeout, expected all words drained"); else n_pass++;
        n_total++;
        if (obs_bit.size() != exp_bit.size()) $display("FAIL rand_count: got %0d bits, expected %0d", obs_bit.size(), exp_bit.size());
        else n_pass++;
        foreach (exp_bit[i]) begin
            n_total++;
            if (i < obs_bit.size() && obs_bit[i] === exp_bit[i] && obs_last[i] === exp_last[i]) n_pass++;
            else $display("FAIL rand_bit%0d: got bit=%b last=%b, expected bit=%b last=%b", i,
                          (i < obs_bit.size()) ? obs_bit[i] : 1'bx, (i < obs_last.size()) ? obs_last[i] : 1'bx,
                          exp_bit[i], exp_last[i]);
        end
    endtask

    initial begin
        test_reset();
        test_msb_a5();
        test_lsb_msb_06();
        test_back_to_back();
        test_backpressure();
        test_len_zero();
        test_len_clamp();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
